// File: rtl/bus_trig_ctrl.sv
`default_nettype none
// =============================================================================
//  Module      : bus_trig_ctrl
//  Description : Brings the tck-domain trigger word into clk, decodes it and
//                gates the bus-tap FIFO capture enable (trigger + post count).
//                Optional match-event counter: define BUS_TRIG_EVT_CNT_EN.
//  Revision    : 1.0 - initial release
// =============================================================================
module bus_trig_ctrl #(
   parameter int trig_width = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [trig_width-1:0] trig_in,
   input  logic [15:0]           bus_addr,
   input  logic                  bus_wr,
   input  logic                  bus_rd,
   output logic                  cap_en,
   output logic                  armed,
   output logic                  triggered
`ifdef BUS_TRIG_EVT_CNT_EN
   ,
   output logic [15:0]           trig_evt_cnt
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   localparam logic [1:0] c_MODE_ANY   = 2'b00;
   localparam logic [1:0] c_MODE_WR    = 2'b01;
   localparam logic [1:0] c_MODE_RD    = 2'b10;

   logic [trig_width-1:0] s1_q, s2_q, s3_q;
   logic [trig_width-1:0] trig_cur_q, trig_cur_d;
   state_t                state_q, state_d;
   logic [12:0]           cnt_q, cnt_d;
   logic                  armed_q, armed_d;
   logic                  triggered_q, triggered_d;

   logic                  w_load;
   logic                  w_arm;
   logic [1:0]            w_mode;
   logic [12:0]           w_post_cnt;
   logic [15:0]           w_cmp_addr;
   logic                  w_any;
   logic                  w_acc;
   logic                  w_match;

   assign w_arm      = trig_cur_q[31];
   assign w_mode     = trig_cur_q[30:29];
   assign w_post_cnt = trig_cur_q[28:16];
   assign w_cmp_addr = trig_cur_q[15:0];
   assign w_any      = bus_wr | bus_rd;

   // Two equal consecutive samples reject words caught mid-update with bit skew.
   assign w_load     = (s2_q == s3_q) && (s2_q != trig_cur_q);

   always_comb begin
      w_acc = 1'b0;
      case (w_mode)
         c_MODE_ANY: w_acc = w_any;
         c_MODE_WR:  w_acc = bus_wr;
         c_MODE_RD:  w_acc = bus_rd;
         default:    w_acc = 1'b0;
      endcase
   end

   assign w_match = w_acc && (bus_addr == w_cmp_addr);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      trig_cur_d = trig_cur_q;
      cap_en     = 1'b0;
      if (w_load) begin
         // A new word discards whatever was in progress, including this cycle's access.
         trig_cur_d = s2_q;
         state_d    = s2_q[31] ? ST_ARMED : ST_IDLE;
      end else begin
         case (state_q)
            ST_ARMED: begin
               if (w_mode == 2'b11) begin
                  state_d = ST_CAPTURE;
                  cnt_d   = w_post_cnt;
               end else if (w_match) begin
                  cap_en = 1'b1;
                  if (w_post_cnt == 13'd0) begin
                     state_d = ST_DONE;
                  end else begin
                     state_d = ST_CAPTURE;
                     cnt_d   = w_post_cnt;
                  end
               end
            end
            ST_CAPTURE: begin
               // Only a forced trigger with zero post count arrives here with cnt 0.
               if (cnt_q == 13'd0) begin
                  state_d = ST_DONE;
               end else if (w_any) begin
                  cap_en = 1'b1;
                  cnt_d  = cnt_q - 13'd1;
                  if (cnt_q == 13'd1) begin
                     state_d = ST_DONE;
                  end
               end
            end
            default: begin
            end
         endcase
      end
      armed_d     = (state_d == ST_ARMED);
      triggered_d = (state_d == ST_CAPTURE) || (state_d == ST_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q        <= '0;
         s2_q        <= '0;
         s3_q        <= '0;
         trig_cur_q  <= '0;
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         armed_q     <= 1'b0;
         triggered_q <= 1'b0;
      end else begin
         s1_q        <= trig_in;
         s2_q        <= s1_q;
         s3_q        <= s2_q;
         trig_cur_q  <= trig_cur_d;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         armed_q     <= armed_d;
         triggered_q <= triggered_d;
      end
   end

   assign armed     = armed_q;
   assign triggered = triggered_q;

`ifdef BUS_TRIG_EVT_CNT_EN
   logic [15:0] evt_cnt_q, evt_cnt_d;

   always_comb begin
      evt_cnt_d = evt_cnt_q;
      if (w_load) begin
         evt_cnt_d = 16'd0;
      end else if (w_arm && w_match && (evt_cnt_q != 16'hFFFF)) begin
         evt_cnt_d = evt_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         evt_cnt_q <= 16'd0;
      end else begin
         evt_cnt_q <= evt_cnt_d;
      end
   end

   assign trig_evt_cnt = evt_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bus_trig_ctrl.sv
`default_nettype none
// =============================================================================
//  Module      : tb_bus_trig_ctrl
//  Description : Randomized scoreboard bench for bus_trig_ctrl against a
//                behavioural trigger model.
//  Revision    : 1.0 - initial release
// =============================================================================
module tb_bus_trig_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] trig_in = 32'd0;
   logic [15:0] bus_addr = 16'd0;
   logic        bus_wr = 1'b0;
   logic        bus_rd = 1'b0;
   logic        cap_en;
   logic        armed;
   logic        triggered;
`ifdef BUS_TRIG_EVT_CNT_EN
   logic [15:0] trig_evt_cnt;
`endif

   always #5 clk = ~clk;

   bus_trig_ctrl #(.trig_width(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .trig_in      (trig_in),
      .bus_addr     (bus_addr),
      .bus_wr       (bus_wr),
      .bus_rd       (bus_rd),
      .cap_en       (cap_en),
      .armed        (armed),
      .triggered    (triggered)
`ifdef BUS_TRIG_EVT_CNT_EN
      ,
      .trig_evt_cnt (trig_evt_cnt)
`endif
   );

   typedef struct packed {
      logic        cap_en;
      logic        armed;
      logic        triggered;
      logic [15:0] evt;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model: phase 0 idle, 1 waiting for trigger, 2 post-capture, 3 done.
   logic [31:0] m_hist [3];   // last three clk samples of trig_in, newest first
   logic [31:0] m_word;
   int          m_phase;
   int          m_left;
   int          m_evt;
   bit          m_valid = 1'b0;

   task automatic model_cycle(input logic r, input logic [31:0] t,
                              input logic [15:0] a, input logic w, input logic rd);
      bit   new_word, access, hit;
      exp_t e;
      new_word = (m_hist[1] == m_hist[2]) && (m_hist[1] != m_word);
      access   = w | rd;
      case (m_word[30:29])
         2'b00:   hit = access;
         2'b01:   hit = w;
         2'b10:   hit = rd;
         default: hit = 1'b0;
      endcase
      hit = hit && (a == m_word[15:0]);

      e.armed     = (m_phase == 1);
      e.triggered = (m_phase >= 2);
      e.evt       = m_evt[15:0];
      e.cap_en    = !new_word && ((m_phase == 1 && hit) ||
                                  (m_phase == 2 && m_left > 0 && access));
      if (m_valid) exp_q.push_back(e);

      if (r) begin
         m_hist[0] = 32'd0; m_hist[1] = 32'd0; m_hist[2] = 32'd0;
         m_word = 32'd0; m_phase = 0; m_left = 0; m_evt = 0;
         m_valid = 1'b1;
      end else begin
         if (new_word) begin
            m_word  = m_hist[1];
            m_phase = m_word[31] ? 1 : 0;
            m_evt   = 0;
         end else begin
            if (m_word[31] && hit && m_evt < 65535) m_evt = m_evt + 1;
            if (m_phase == 1) begin
               if (m_word[30:29] == 2'b11) begin
                  m_left  = int'(m_word[28:16]);
                  m_phase = 2;
               end else if (hit) begin
                  m_left  = int'(m_word[28:16]);
                  m_phase = (m_left == 0) ? 3 : 2;
               end
            end else if (m_phase == 2) begin
               if (m_left == 0) begin
                  m_phase = 3;
               end else if (access) begin
                  m_left = m_left - 1;
                  if (m_left == 0) m_phase = 3;
               end
            end
         end
         m_hist[2] = m_hist[1];
         m_hist[1] = m_hist[0];
         m_hist[0] = t;
      end
   endtask

   task automatic cyc(input logic r, input logic [31:0] t,
                      input logic [15:0] a, input logic w, input logic rd);
      @(posedge clk);
      #1;
      rst = r; trig_in = t; bus_addr = a; bus_wr = w; bus_rd = rd;
      model_cycle(r, t, a, w, rd);
   endtask

   task automatic idle(input logic [31:0] t, input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, t, 16'h0000, 1'b0, 1'b0);
   endtask

   // Monitor: compare the DUT against the oldest pending expectation.
   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (cap_en !== e.cap_en) begin
            errors++;
            $display("FAIL cap_en t=%0t got=%b exp=%b", $time, cap_en, e.cap_en);
         end
         checks++;
         if (armed !== e.armed) begin
            errors++;
            $display("FAIL armed t=%0t got=%b exp=%b", $time, armed, e.armed);
         end
         checks++;
         if (triggered !== e.triggered) begin
            errors++;
            $display("FAIL triggered t=%0t got=%b exp=%b", $time, triggered, e.triggered);
         end
`ifdef BUS_TRIG_EVT_CNT_EN
         checks++;
         if (trig_evt_cnt !== e.evt) begin
            errors++;
            $display("FAIL trig_evt_cnt t=%0t got=%0d exp=%0d", $time, trig_evt_cnt, e.evt);
         end
`endif
      end
   end

   initial begin
      logic [31:0] w;
      int          hold, kind;
      logic [15:0] a;

      // Reset: first cycle has unknown DUT state and is not scored.
      cyc(1'b1, 32'd0, 16'd0, 1'b0, 1'b0);
      cyc(1'b1, 32'd0, 16'd0, 1'b0, 1'b0);
      idle(32'd0, 2);

      // Arm, any access, post 0: single enabled access, later match ignored.
      idle(32'h8000_1234, 5);
      cyc(1'b0, 32'h8000_1234, 16'h1234, 1'b1, 1'b0);
      idle(32'h8000_1234, 2);
      cyc(1'b0, 32'h8000_1234, 16'h1234, 1'b1, 1'b0);
      idle(32'h8000_1234, 1);

      // Write-only, post 3, gaps between accesses.
      idle(32'hA003_0040, 5);
      cyc(1'b0, 32'hA003_0040, 16'h0040, 1'b0, 1'b1);
      idle(32'hA003_0040, 1);
      cyc(1'b0, 32'hA003_0040, 16'h0040, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) begin
         idle(32'hA003_0040, 2);
         cyc(1'b0, 32'hA003_0040, 16'h0100, 1'b0, 1'b1);
      end

      // Forced trigger, post 2.
      idle(32'hE002_0000, 6);
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 32'hE002_0000, 16'h0000, 1'b1, 1'b0);
         idle(32'hE002_0000, 1);
      end

      // Abort a capture by loading an all-zero word.
      idle(32'hA003_0040, 5);
      cyc(1'b0, 32'hA003_0040, 16'h0040, 1'b1, 1'b0);
      cyc(1'b0, 32'hA003_0040, 16'h0040, 1'b1, 1'b0);
      for (int i = 0; i < 6; i++) cyc(1'b0, 32'h0000_0000, 16'h0040, 1'b1, 1'b0);

      // Load and match coincide: load cycle is the fourth after the change.
      idle(32'h8000_1234, 5);
      idle(32'h8001_1234, 3);
      for (int i = 0; i < 4; i++) cyc(1'b0, 32'h8001_1234, 16'h1234, 1'b1, 1'b0);

      // Skewed update over two cycles: only the settled word may load.
      cyc(1'b0, 32'h8000_0000, 16'h0000, 1'b0, 1'b0);
      cyc(1'b0, 32'h4002_1234, 16'h0000, 1'b0, 1'b0);
      idle(32'hC002_1234, 5);
      for (int i = 0; i < 4; i++) begin
         cyc(1'b0, 32'hC002_1234, 16'h1234, 1'b0, 1'b1);
         idle(32'hC002_1234, 1);
      end

      // Matches after DONE keep counting events.
      idle(32'h0000_0000, 5);
      idle(32'h8000_1234, 5);
      for (int i = 0; i < 6; i++) begin
         cyc(1'b0, 32'h8000_1234, 16'h1234, 1'b1, 1'b0);
         idle(32'h8000_1234, 1);
      end
      idle(32'h0000_1234, 5);

      // Mid-capture reset.
      idle(32'hA004_0040, 5);
      cyc(1'b0, 32'hA004_0040, 16'h0040, 1'b1, 1'b0);
      cyc(1'b1, 32'hA004_0040, 16'h0040, 1'b1, 1'b0);
      for (int i = 0; i < 6; i++) cyc(1'b0, 32'hA004_0040, 16'h0040, 1'b1, 1'b0);

      // Randomized segments.
      for (int s = 0; s < 400; s++) begin
         w = {($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
              13'($urandom_range(0, 3)),
              ($urandom_range(0, 1) != 0) ? 16'h0040 : 16'h1234};
         hold = $urandom_range(1, 10);
         for (int c = 0; c < hold; c++) begin
            kind = $urandom_range(0, 3);
            a    = ($urandom_range(0, 3) != 0) ? w[15:0] : 16'($urandom_range(0, 65535));
            cyc(($urandom_range(0, 299) == 0), w, a, (kind == 1), (kind == 2));
         end
      end

      idle(32'd0, 2);
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain pending=%0d exp=0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
